// File: rtl/tt_um_logic_sequencer.sv
// rtl/tt_um_logic_sequencer.sv - two-operand logic sequencer with a shared multi-cycle logic unit
// Strobes on uio_in[3:0] are synchronized and edge-detected; the FSM captures A, then B/op, then computes.
module tt_um_logic_sequencer #(
  parameter int EXEC_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GOT_A = 2'd1,
    EXEC  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  state_t     state;
  logic [3:0] sync1, sync2, hist;
  logic [3:0] ev;
  logic       wr_ev, clr_ev;
  logic [7:0] a, b;
  logic [1:0] op;
  logic [3:0] cnt;
  logic       busy, done, err, ready;
  logic       unused_ok;

  // The synchronizer and history keep running while disabled, so a strobe
  // seen during ena=0 is consumed rather than replayed when ena returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      hist  <= '0;
    end else begin
      sync1 <= uio_in[3:0];
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign ev        = sync2 & ~hist & {4{ena}};
  assign wr_ev     = ev[0];
  assign clr_ev    = ev[3];
  assign unused_ok = &{1'b0, uio_in[7:4], ev[2:1]};

  function automatic logic [7:0] logic_unit(input logic [7:0] x, input logic [7:0] y,
                                            input logic [1:0] sel);
    case (sel)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return ~(x & y);
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a      <= '0;
      b      <= '0;
      op     <= '0;
      cnt    <= '0;
      uo_out <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      ready  <= 1'b1;
    end else if (ena) begin
      if (clr_ev) begin
        state  <= IDLE;
        a      <= '0;
        b      <= '0;
        op     <= '0;
        cnt    <= '0;
        uo_out <= '0;
        busy   <= 1'b0;
        done   <= 1'b0;
        err    <= 1'b0;
        ready  <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (wr_ev) begin
              a     <= ui_in;
              err   <= 1'b0;
              state <= GOT_A;
            end
          end
          GOT_A: begin
            if (wr_ev) begin
              b     <= ui_in;
              op    <= uio_in[2:1];
              cnt   <= CNT_INIT;
              busy  <= 1'b1;
              ready <= 1'b0;
              state <= EXEC;
            end
          end
          EXEC: begin
            // A write while busy is dropped but remembered as an error.
            if (wr_ev) err <= 1'b1;
            if (cnt == 4'd0) begin
              uo_out <= logic_unit(a, b, op);
              done   <= 1'b1;
              busy   <= 1'b0;
              ready  <= 1'b1;
              state  <= DONE;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          DONE: begin
            if (wr_ev) begin
              a     <= ui_in;
              done  <= 1'b0;
              err   <= 1'b0;
              state <= GOT_A;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign uio_out = {ready, err, done, busy, 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_logic_sequencer.sv
// tb/tb_tt_um_logic_sequencer.sv - directed self-checking bench for tt_um_logic_sequencer
module tb_tt_um_logic_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, ena, ena4;
  logic [7:0] ui_in, uio_in;
  wire  [7:0] uo_out, uio_out, uio_oe;
  wire  [7:0] uo_out4, uio_out4, uio_oe4;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] prev;
  logic [7:0] exp_ops [4];

  always #5 clk = ~clk;

  tt_um_logic_sequencer dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  tt_um_logic_sequencer #(.EXEC_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .ena(ena4), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out4), .uio_out(uio_out4), .uio_oe(uio_oe4)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Returns half a cycle after the capture edge (third edge after strobe rise).
  task automatic wr(input logic [7:0] d, input logic [1:0] opc);
    repeat (2) @(negedge clk);
    ui_in      = d;
    uio_in[2:1] = opc;
    uio_in[0]  = 1'b1;
    repeat (3) @(negedge clk);
    uio_in[0]  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ena4   = 1'b0;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    exp_ops[0] = 8'h0A; exp_ops[1] = 8'hAF; exp_ops[2] = 8'hA5; exp_ops[3] = 8'hF5;

    repeat (2) @(negedge clk);
    check("rst_uo", uo_out, 8'h00);
    check("rst_uio", uio_out, 8'h80);
    check("rst_oe", uio_oe, 8'hF0);
    rst_n = 1'b1;

    // F0 ^ 3C with two-cycle occupancy
    wr(8'hF0, 2'b00);
    check("gota_flags", uio_out, 8'h80);
    wr(8'h3C, 2'b10);
    check("busy_c1", uio_out, 8'h10);
    check("busy_c1_uo", uo_out, 8'h00);
    @(negedge clk);
    check("busy_c2", uio_out, 8'h10);
    check("busy_c2_uo", uo_out, 8'h00);
    @(negedge clk);
    check("xor_res", uo_out, 8'hCC);
    check("xor_flags", uio_out, 8'hA0);

    // all opcodes, AA op 0F
    prev = 8'hCC;
    for (int i = 0; i < 4; i++) begin
      wr(8'hAA, 2'b00);
      check("newa_flags", uio_out, 8'h80);
      check("newa_hold", uo_out, prev);
      wr(8'h0F, 2'(i));
      repeat (2) @(negedge clk);
      check("op_res", uo_out, exp_ops[i]);
      check("op_flags", uio_out, 8'hA0);
      prev = exp_ops[i];
    end

    // write during EXEC: sticky err, data ignored
    wr(8'h12, 2'b00);
    repeat (2) @(negedge clk);
    ui_in = 8'h34; uio_in[2:1] = 2'b00; uio_in[0] = 1'b1;
    @(negedge clk); uio_in[0] = 1'b0;
    @(negedge clk); uio_in[0] = 1'b1;
    @(negedge clk); ui_in = 8'hFF; uio_in[2:1] = 2'b01; uio_in[0] = 1'b0;
    check("err_busy1", uio_out, 8'h10);
    @(negedge clk);
    check("err_busy2", uio_out, 8'h10);
    @(negedge clk);
    check("err_res", uo_out, 8'h10);
    check("err_flags", uio_out, 8'hE0);
    wr(8'h55, 2'b00);
    check("err_clear", uio_out, 8'h80);
    check("err_hold", uo_out, 8'h10);

    // clr and wr together in GOT_A
    repeat (2) @(negedge clk);
    ui_in = 8'h99; uio_in[3] = 1'b1; uio_in[0] = 1'b1;
    repeat (3) @(negedge clk);
    uio_in[3] = 1'b0; uio_in[0] = 1'b0;
    check("clr_uo", uo_out, 8'h00);
    check("clr_flags", uio_out, 8'h80);
    wr(8'hF0, 2'b00);
    wr(8'h3C, 2'b10);
    repeat (2) @(negedge clk);
    check("clr_after", uo_out, 8'hCC);

    // asynchronous reset mid-EXEC
    wr(8'h11, 2'b00);
    wr(8'h22, 2'b01);
    check("ar_busy", uio_out, 8'h10);
    #1 rst_n = 1'b0;
    #1;
    check("ar_uo", uo_out, 8'h00);
    check("ar_uio", uio_out, 8'h80);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("ar_nowrite", uo_out, 8'h00);
    check("ar_idle", uio_out, 8'h80);
    wr(8'h0F, 2'b00);
    wr(8'hF0, 2'b01);
    repeat (2) @(negedge clk);
    check("ar_res", uo_out, 8'hFF);
    check("ar_flags", uio_out, 8'hA0);

    // strobe held high across reset release: exactly one event
    @(negedge clk);
    ui_in = 8'h77; uio_in[2:1] = 2'b00; uio_in[0] = 1'b1; rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(negedge clk);
    uio_in[0] = 1'b0;
    check("held_gota", uio_out, 8'h80);
    wr(8'h0F, 2'b00);
    repeat (2) @(negedge clk);
    check("held_res", uo_out, 8'h07);
    check("held_flags", uio_out, 8'hA0);

    // ena pause mid-EXEC on the EXEC_CYCLES=4 instance
    ena  = 1'b0;
    ena4 = 1'b1;
    wr(8'hC3, 2'b00);
    check("p_gota", uio_out4, 8'h80);
    wr(8'h5A, 2'b10);
    check("p_busy0", uio_out4, 8'h10);
    @(negedge clk); ena4 = 1'b0;
    @(negedge clk); ui_in = 8'hEE; uio_in[0] = 1'b1;
    check("p_busy1", uio_out4, 8'h10);
    @(negedge clk); uio_in[0] = 1'b0;
    repeat (2) @(negedge clk);
    check("p_frozen", uio_out4, 8'h10);
    check("p_frozen_uo", uo_out4, 8'h00);
    @(negedge clk); ena4 = 1'b1;
    repeat (2) @(negedge clk);
    check("p_e8", uio_out4, 8'h10);
    check("p_e8_uo", uo_out4, 8'h00);
    @(negedge clk);
    check("p_res", uo_out4, 8'h99);
    check("p_flags", uio_out4, 8'hA0);
    check("p_oe", uio_oe4, 8'hF0);

    // disabled instance ignored the strobes and shows no stale event
    ena = 1'b1;
    repeat (4) @(negedge clk);
    check("dis_flags", uio_out, 8'hA0);
    check("dis_uo", uo_out, 8'h07);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
